// File: rtl/ddr_arb_pkg.sv
// rtl/ddr_arb_pkg.sv - FSM state type, default widths and round-robin wrap helper.
package ddr_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2
   } arb_state_e;

   localparam int DEF_ADDR_WIDTH = 26;
   localparam int DEF_DATA_WIDTH = 128;
   localparam int DEF_NUM_PORTS  = 2;
   localparam int DEF_TIMEOUT    = 255;

   // Operand never exceeds 2*n-1, so a single subtract replaces a modulo.
   function automatic int rr_wrap(input int v, input int n);
      return (v >= n) ? v - n : v;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin pick: search starts one past the last winner (ptr).
module rr_arbiter
   import ddr_arb_pkg::*;
#(
   parameter int NUM_PORTS = DEF_NUM_PORTS,
   parameter int PW        = $clog2(NUM_PORTS)
) (
   input  logic [NUM_PORTS-1:0] req,
   input  logic [PW-1:0]        ptr,
   output logic [NUM_PORTS-1:0] gnt,
   output logic [PW-1:0]        idx,
   output logic                 valid
);

   logic [PW-1:0] cand;

   always_comb begin
      gnt   = '0;
      idx   = '0;
      valid = 1'b0;
      cand  = '0;
      for (int off = 1; off <= NUM_PORTS; off++) begin
         cand = PW'(rr_wrap(int'(ptr) + off, NUM_PORTS));
         if (!valid && req[cand]) begin
            valid     = 1'b1;
            idx       = cand;
            gnt[cand] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/ddr_port_arbiter.sv
// rtl/ddr_port_arbiter.sv - multi-port DDR front end, one transaction in flight.
// Define DDR_ARB_TIMEOUT_EN to enable the WAIT-state watchdog (err_o pulses).
module ddr_port_arbiter
   import ddr_arb_pkg::*;
#(
   parameter int DDR_ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int DDR_DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int NUM_PORTS      = DEF_NUM_PORTS,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT
) (
   input  logic                                phy_clk,
   input  logic                                rst_n,
   input  logic [NUM_PORTS-1:0]                req_i,
   input  logic [NUM_PORTS-1:0]                we_i,
   input  logic [NUM_PORTS*DDR_ADDR_WIDTH-1:0] addr_i,
   input  logic [NUM_PORTS*DDR_DATA_WIDTH-1:0] wdata_i,
   output logic [NUM_PORTS-1:0]                gnt_o,
   output logic [NUM_PORTS-1:0]                done_o,
   output logic [DDR_DATA_WIDTH-1:0]           rdata_o,
   output logic [NUM_PORTS-1:0]                err_o,
   input  logic                                local_init_done,
   input  logic                                local_ready,
   input  logic                                local_rdata_valid,
   input  logic [DDR_DATA_WIDTH-1:0]           local_rdata,
   output logic [DDR_ADDR_WIDTH-1:0]           local_address,
   output logic                                local_burstbegin,
   output logic                                local_read_req,
   output logic                                local_write_req,
   output logic [DDR_DATA_WIDTH-1:0]           local_wdata
);

   localparam int PW = $clog2(NUM_PORTS);

   arb_state_e               state_q, state_d;
   logic [PW-1:0]            ptr_q, ptr_d, owner_q, owner_d;
   logic                     rst_done_q, we_q, we_d;
   logic [DDR_ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DDR_DATA_WIDTH-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
   logic [NUM_PORTS-1:0]     gnt_q, gnt_d, done_q, done_d;
   logic                     burst_q, burst_d, rd_q, rd_d, wr_q, wr_d;

   logic [NUM_PORTS-1:0]     arb_gnt;
   logic [PW-1:0]            arb_idx;
   logic                     arb_valid;

   rr_arbiter #(.NUM_PORTS(NUM_PORTS), .PW(PW)) u_rr (
      .req   (req_i),
      .ptr   (ptr_q),
      .gnt   (arb_gnt),
      .idx   (arb_idx),
      .valid (arb_valid)
   );

`ifdef DDR_ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [NUM_PORTS-1:0] err_q, err_d;
`else
   logic unused_timeout;
   assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      owner_d = owner_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      gnt_d   = '0;
      done_d  = '0;
      burst_d = 1'b0;
      rd_d    = 1'b0;
      wr_d    = 1'b0;
`ifdef DDR_ARB_TIMEOUT_EN
      cnt_d   = cnt_q;
      err_d   = '0;
`endif
      case (state_q)
         ST_IDLE: begin
            // rst_done_q keeps the first edge after reset release from accepting.
            if (rst_done_q && local_init_done && arb_valid) begin
               owner_d = arb_idx;
               ptr_d   = arb_idx;
               we_d    = we_i[arb_idx];
               addr_d  = addr_i[arb_idx*DDR_ADDR_WIDTH +: DDR_ADDR_WIDTH];
               wdata_d = wdata_i[arb_idx*DDR_DATA_WIDTH +: DDR_DATA_WIDTH];
               gnt_d   = arb_gnt;
               burst_d = 1'b1;
               wr_d    = we_i[arb_idx];
               rd_d    = !we_i[arb_idx];
               state_d = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            state_d = ST_WAIT;
`ifdef DDR_ARB_TIMEOUT_EN
            cnt_d   = '0;
`endif
         end
         ST_WAIT: begin
            if (we_q ? local_ready : local_rdata_valid) begin
               done_d[owner_q] = 1'b1;
               if (!we_q) rdata_d = local_rdata;
               state_d = ST_IDLE;
            end
`ifdef DDR_ARB_TIMEOUT_EN
            else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
               done_d[owner_q] = 1'b1;
               err_d[owner_q]  = 1'b1;
               rdata_d         = '0;
               state_d         = ST_IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
`endif
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge phy_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         ptr_q      <= PW'(NUM_PORTS - 1);
         owner_q    <= '0;
         rst_done_q <= 1'b0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         rdata_q    <= '0;
         gnt_q      <= '0;
         done_q     <= '0;
         burst_q    <= 1'b0;
         rd_q       <= 1'b0;
         wr_q       <= 1'b0;
`ifdef DDR_ARB_TIMEOUT_EN
         cnt_q      <= '0;
         err_q      <= '0;
`endif
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         owner_q    <= owner_d;
         rst_done_q <= 1'b1;
         we_q       <= we_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         rdata_q    <= rdata_d;
         gnt_q      <= gnt_d;
         done_q     <= done_d;
         burst_q    <= burst_d;
         rd_q       <= rd_d;
         wr_q       <= wr_d;
`ifdef DDR_ARB_TIMEOUT_EN
         cnt_q      <= cnt_d;
         err_q      <= err_d;
`endif
      end
   end

   assign gnt_o            = gnt_q;
   assign done_o           = done_q;
   assign rdata_o          = rdata_q;
   assign local_address    = addr_q;
   assign local_wdata      = wdata_q;
   assign local_burstbegin = burst_q;
   assign local_read_req   = rd_q;
   assign local_write_req  = wr_q;
`ifdef DDR_ARB_TIMEOUT_EN
   assign err_o            = err_q;
`else
   assign err_o            = '0;
`endif

endmodule

// File: tb/tb_ddr_port_arbiter.sv
// tb/tb_ddr_port_arbiter.sv - directed bench for ddr_port_arbiter with a one-cycle DDR model.
// Timeout checks run only when DDR_ARB_TIMEOUT_EN is defined.
module tb_ddr_port_arbiter;

   localparam int NP = 2;
   localparam int AW = 26;
   localparam int DW = 128;
   localparam int TO = 8;

   logic              phy_clk = 1'b0;
   logic              rst_n   = 1'b0;
   logic [NP-1:0]     req_i   = '0;
   logic [NP-1:0]     we_i    = '0;
   logic [NP*AW-1:0]  addr_i  = '0;
   logic [NP*DW-1:0]  wdata_i = '0;
   logic [NP-1:0]     gnt_o, done_o, err_o;
   logic [DW-1:0]     rdata_o;
   logic              local_init_done   = 1'b0;
   logic              local_ready       = 1'b0;
   logic              local_rdata_valid = 1'b0;
   logic [DW-1:0]     local_rdata       = '0;
   logic [AW-1:0]     local_address;
   logic              local_burstbegin, local_read_req, local_write_req;
   logic [DW-1:0]     local_wdata;

   ddr_port_arbiter #(
      .DDR_ADDR_WIDTH(AW), .DDR_DATA_WIDTH(DW), .NUM_PORTS(NP), .TIMEOUT_CYCLES(TO)
   ) dut (
      .phy_clk(phy_clk), .rst_n(rst_n), .req_i(req_i), .we_i(we_i),
      .addr_i(addr_i), .wdata_i(wdata_i), .gnt_o(gnt_o), .done_o(done_o),
      .rdata_o(rdata_o), .err_o(err_o), .local_init_done(local_init_done),
      .local_ready(local_ready), .local_rdata_valid(local_rdata_valid),
      .local_rdata(local_rdata), .local_address(local_address),
      .local_burstbegin(local_burstbegin), .local_read_req(local_read_req),
      .local_write_req(local_write_req), .local_wdata(local_wdata)
   );

   always #5 phy_clk = ~phy_clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(negedge phy_clk);
   endtask

   // One-cycle DDR: a request seen in ISSUE is answered in the following cycle.
   logic          ddr_en = 1'b0;
   logic          pend   = 1'b0;
   logic [DW-1:0] pend_data = '0;
   logic [DW-1:0] mem [logic [AW-1:0]];

   initial forever begin
      @(negedge phy_clk);
      local_rdata_valid = pend;
      local_rdata       = pend ? pend_data : '0;
      pend              = 1'b0;
      if (ddr_en && local_read_req) begin
         pend      = 1'b1;
         pend_data = mem.exists(local_address) ? mem[local_address] : '0;
      end
      if (ddr_en && local_write_req) mem[local_address] = local_wdata;
      local_ready = ddr_en;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "bench watchdog expired");
   end

   localparam logic [DW-1:0] PAT_A5 = {16{8'hA5}};
   localparam logic [DW-1:0] PAT_3C = {16{8'h3C}};

   bit seen;
   bit got;

   initial begin
      repeat (2) cyc();
      check("rst_gnt",   gnt_o, 0);
      check("rst_done",  done_o, 0);
      check("rst_err",   err_o, 0);
      check("rst_strb",  {local_burstbegin, local_write_req, local_read_req}, 0);
      check("rst_addr",  local_address, 0);
      check("rst_wdata", local_wdata, 0);
      check("rst_rdata", rdata_o, 0);

      rst_n = 1'b1;
      req_i = 2'b11;
      seen  = 1'b0;
      repeat (10) begin
         cyc();
         seen |= (gnt_o != 0) || local_read_req || local_write_req || local_burstbegin;
      end
      check("init_low_quiet", seen, 0);

      req_i = '0;
      local_init_done = 1'b1;
      ddr_en = 1'b1;
      repeat (2) cyc();

      // Port 0 write of 0xA5.. to line 0x10.
      we_i    = 2'b01;
      addr_i  = {26'h0, 26'h10};
      wdata_i = {PAT_3C, PAT_A5};
      req_i   = 2'b01;
      cyc();
      check("wr_gnt",  gnt_o, 2'b01);
      check("wr_strb", {local_burstbegin, local_write_req, local_read_req}, 3'b110);
      check("wr_addr", local_address, 26'h10);
      check("wr_data", local_wdata, PAT_A5);
      req_i = '0;
      cyc();
      check("wr_strb_once", {local_burstbegin, local_write_req, local_read_req}, 0);
      cyc();
      check("wr_done", done_o, 2'b01);
      check("wr_err",  err_o, 0);

      // Port 1 read of line 0x10, three edges from request to data.
      we_i   = 2'b00;
      addr_i = {26'h10, 26'h0};
      req_i  = 2'b10;
      cyc();
      check("rd_gnt",  gnt_o, 2'b10);
      check("rd_strb", {local_burstbegin, local_write_req, local_read_req}, 3'b101);
      check("rd_addr", local_address, 26'h10);
      req_i = '0;
      cyc();
      check("rd_gnt_pulse",  gnt_o, 0);
      check("rd_done_early", done_o, 0);
      cyc();
      check("rd_done",  done_o, 2'b10);
      check("rd_rdata", rdata_o, PAT_A5);

      // Both ports held: grants alternate 0,1,0,1.
      we_i    = 2'b11;
      addr_i  = {26'h21, 26'h20};
      wdata_i = {PAT_3C, PAT_3C};
      req_i   = 2'b11;
      for (int k = 0; k < 4; k++) begin
         got = 1'b0;
         for (int t = 0; t < 10 && !got; t++) begin
            cyc();
            if (gnt_o != 0) got = 1'b1;
         end
         check($sformatf("rr_gnt%0d", k), gnt_o, (k % 2 == 0) ? 2'b01 : 2'b10);
         if (k == 3) req_i = '0;
      end
      repeat (3) cyc();
      check("rdata_hold", rdata_o, PAT_A5);

      // Reset while stuck in WAIT on an unanswered read.
      ddr_en = 1'b0;
      repeat (2) cyc();
      we_i   = 2'b00;
      addr_i = {26'h0, 26'h10};
      req_i  = 2'b01;
      got = 1'b0;
      for (int t = 0; t < 10 && !got; t++) begin
         cyc();
         if (gnt_o[0]) got = 1'b1;
      end
      check("stall_gnt", got, 1);
      req_i = '0;
      repeat (3) cyc();
      check("stall_no_err", err_o, 0);
      rst_n = 1'b0;
      #1;
      check("midrst_gnt",   gnt_o, 0);
      check("midrst_done",  done_o, 0);
      check("midrst_strb",  {local_burstbegin, local_write_req, local_read_req}, 0);
      check("midrst_addr",  local_address, 0);
      check("midrst_rdata", rdata_o, 0);
      cyc();
      rst_n  = 1'b1;
      ddr_en = 1'b1;
      seen   = 1'b0;
      repeat (6) begin
         cyc();
         seen |= (done_o != 0);
      end
      check("no_done_after_rst", seen, 0);

      // Request present at release: first edge ignores it, second accepts.
      rst_n = 1'b0;
      cyc();
      rst_n = 1'b1;
      we_i  = 2'b00;
      req_i = 2'b01;
      cyc();
      check("rel_edge1_no_gnt", gnt_o, 0);
      cyc();
      check("rel_edge2_gnt", gnt_o, 2'b01);
      req_i = '0;
      repeat (2) cyc();
      check("rel_rd_rdata", rdata_o, PAT_A5);

`ifdef DDR_ARB_TIMEOUT_EN
      ddr_en = 1'b0;
      repeat (2) cyc();
      we_i  = 2'b00;
      req_i = 2'b10;
      cyc();
      check("tmo_gnt", gnt_o, 2'b10);
      req_i = '0;
      seen  = 1'b0;
      repeat (8) begin
         cyc();
         seen |= (done_o != 0) || (err_o != 0);
      end
      check("tmo_not_early", seen, 0);
      cyc();
      check("tmo_done",  done_o, 2'b10);
      check("tmo_err",   err_o, 2'b10);
      check("tmo_rdata", rdata_o, 0);
      ddr_en = 1'b1;
      we_i   = 2'b01;
      req_i  = 2'b01;
      cyc();
      check("tmo_idle_gnt", gnt_o, 2'b01);
      check("tmo_err_pulse", err_o, 0);
      req_i = '0;
      repeat (3) cyc();
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/ddr_port_arbiter.md
DDR_PORT_ARBITER -- requirements
Module: ddr_port_arbiter

Interface
REQ-001 SHALL have parameter DDR_ADDR_WIDTH, default 26, DDR line address width.
REQ-002 SHALL have parameter DDR_DATA_WIDTH, default 128, DDR line data width.
REQ-003 SHALL have parameter NUM_PORTS, default 2, requester count, legal range 2..8.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 255, watchdog limit (used only under REQ-031).
REQ-005 SHALL have port phy_clk  in  1  the single clock; all logic on its rising edge.
REQ-006 SHALL have port rst_n  in  1  reset, asynchronous assert, active-low.
REQ-007 SHALL have port req_i  in  NUM_PORTS  per-port request; port p held until gnt_o[p].
REQ-008 SHALL have port we_i  in  NUM_PORTS  per-port write(1)/read(0).
REQ-009 SHALL have port addr_i  in  NUM_PORTS*DDR_ADDR_WIDTH  flattened per-port address; port p at slice p.
REQ-010 SHALL have port wdata_i  in  NUM_PORTS*DDR_DATA_WIDTH  flattened per-port write data.
REQ-011 SHALL have port gnt_o  out  NUM_PORTS  one-cycle acceptance pulse.
REQ-012 SHALL have port done_o  out  NUM_PORTS  one-cycle completion pulse, reads and writes.
REQ-013 SHALL have port rdata_o  out  DDR_DATA_WIDTH  read data, shared, valid with done_o of a read.
REQ-014 SHALL have port err_o  out  NUM_PORTS  one-cycle timeout pulse, coincident with done_o.
REQ-015 SHALL have DDR-side ports local_init_done, local_ready, local_rdata_valid (1b in), local_rdata (DDR_DATA_WIDTH in), local_address (DDR_ADDR_WIDTH out), local_burstbegin, local_read_req, local_write_req (1b out), local_wdata (DDR_DATA_WIDTH out).

Function
REQ-016 SHALL implement FSM states IDLE, ISSUE, WAIT; all outputs registered.
REQ-017 In IDLE with local_init_done=0, SHALL ignore all requests and stay in IDLE.
REQ-018 In IDLE with local_init_done=1 and any req_i set, SHALL pick winner round-robin, starting search at (last winner+1) mod NUM_PORTS; after reset search starts at port 0.
REQ-019 On the winning edge SHALL latch winner addr/wdata/we, pulse gnt_o[winner] next cycle, enter ISSUE.
REQ-020 In ISSUE SHALL drive local_burstbegin=1 and exactly one of local_write_req/local_read_req=1 for exactly one cycle, then enter WAIT.
REQ-021 local_address/local_wdata SHALL hold the latched values from ISSUE through WAIT.
REQ-022 In WAIT SHALL complete a write on local_ready=1, a read on local_rdata_valid=1 (capturing local_rdata), pulse done_o[owner] next cycle, return to IDLE.
REQ-023 Response strobes arriving in IDLE or ISSUE SHALL be ignored.
REQ-024 Read latency against a one-cycle DDR: req sampled edge E0 -> gnt_o cycle E0+1, done_o/rdata_o valid after E2 (3 edges total).
REQ-025 Back-to-back: IDLE re-arbitrates on the edge after done_o; a port at most one transaction outstanding.
REQ-026 rdata_o SHALL hold its last value until the next read completes.
REQ-027 Requests deasserted before gnt_o SHALL be dropped without side effect.

Reset
REQ-028 rst_n=0 SHALL force IDLE, round-robin pointer to port NUM_PORTS-1 (search begins at 0), all 1-bit outputs 0, local_address/local_wdata/rdata_o 0.
REQ-029 Reset mid-transaction SHALL abort it with no done_o; no completion pulse after release.
REQ-030 The next request SHALL be accepted no earlier than the second edge after rst_n rises.

Configuration
REQ-031 With DDR_ARB_TIMEOUT_EN defined, a WAIT-state counter SHALL, on reaching TIMEOUT_CYCLES, return to IDLE pulsing done_o[owner] and err_o[owner], rdata_o=0.
REQ-032 Without DDR_ARB_TIMEOUT_EN, WAIT SHALL persist until the response strobe and err_o SHALL be tied 0.

Structure
REQ-033 Package ddr_arb_pkg SHALL hold the FSM state typedef and default-width constants.
REQ-034 Round-robin selection SHALL be sub-module rr_arbiter (req vector, pointer -> one-hot grant, valid).

Verification
REQ-035 Reset, init_done=0 for 10 cycles with req_i=2'b11 -> no gnt_o, no local_*_req.
REQ-036 Port0 write addr 0x10 data 0xA5..., then port1 read 0x10 -> port1 done_o with rdata_o=0xA5..., 3-edge read latency.
REQ-037 req_i=2'b11 held for 4 transactions -> grants alternate 0,1,0,1.
REQ-038 rst_n low during WAIT -> all outputs 0, no done_o after release.
REQ-039 DDR_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, DDR never responds -> err_o and done_o on owner after 8 WAIT cycles, FSM back to IDLE.
